// File: rtl/cache_axi_rd_arbiter.sv
// Shares one AXI4 read port (AR + R) between the I-cache and D-cache refill engines.
// Optional ARB_RR_EN: round-robin between the two clients instead of fixed D-over-I priority.
module cache_axi_rd_arbiter #(
    parameter logic [3:0] ID_I = 4'd0,
    parameter logic [3:0] ID_D = 4'd1
) (
    input  logic        clk,
    input  logic        rstn,
    // I-cache side
    input  logic        i_r_req,
    input  logic [31:0] i_r_addr,
    input  logic [7:0]  i_r_length,
    input  logic [2:0]  i_r_size,
    output logic        i_r_rdy,
    input  logic        i_r_data_ready,
    output logic        i_ret_valid,
    output logic        i_ret_last,
    output logic [31:0] i_ret_data,
    // D-cache side
    input  logic        d_r_req,
    input  logic [31:0] d_r_addr,
    input  logic [7:0]  d_r_length,
    input  logic [2:0]  d_r_size,
    output logic        d_r_rdy,
    input  logic        d_r_data_ready,
    output logic        d_ret_valid,
    output logic        d_ret_last,
    output logic [31:0] d_ret_data,
    // AXI AR channel
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [3:0]  arid,
    output logic        arvalid,
    input  logic        arready,
    // AXI R channel
    input  logic [31:0] rdata,
    input  logic [3:0]  rid,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_req_t;

    logic [1:0] state;
    logic       own_i, own_d;
    logic       win_d, any_req, in_r, ar_hs, burst_done;
    ar_req_t    sel_req;

    assign any_req    = i_r_req | d_r_req;
    assign in_r       = (state == S_R);
    assign ar_hs      = arvalid & arready;
    assign burst_done = in_r & rvalid & rready & rlast;

`ifdef ARB_RR_EN
    // Remembers who finished the last burst; resets to I so D wins the first contention.
    logic last_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            last_d <= 1'b0;
        else if (burst_done)
            last_d <= own_d;
    end

    assign win_d = d_r_req & (~i_r_req | ~last_d);
`else
    assign win_d = d_r_req;
`endif

    assign sel_req = win_d ? ar_req_t'{d_r_addr, d_r_length, d_r_size}
                           : ar_req_t'{i_r_addr, i_r_length, i_r_size};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            own_i   <= 1'b0;
            own_d   <= 1'b0;
            arvalid <= 1'b0;
            araddr  <= '0;
            arlen   <= '0;
            arsize  <= '0;
            arid    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        araddr  <= sel_req.addr;
                        arlen   <= sel_req.len;
                        arsize  <= sel_req.size;
                        arid    <= win_d ? ID_D : ID_I;
                        own_d   <= win_d;
                        own_i   <= ~win_d;
                        arvalid <= 1'b1;
                        state   <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        state   <= S_R;
                    end
                end
                S_R: begin
                    if (burst_done) begin
                        own_i <= 1'b0;
                        own_d <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign arburst = 2'b01;

    // Beats are passed straight through; backpressure comes from the owner only.
    assign rready = in_r & ((own_d & d_r_data_ready) | (own_i & i_r_data_ready));

    assign i_r_rdy = ar_hs & own_i;
    assign d_r_rdy = ar_hs & own_d;

    assign i_ret_valid = in_r & own_i & rvalid;
    assign i_ret_last  = in_r & own_i & rlast;
    assign i_ret_data  = (in_r & own_i) ? rdata : '0;
    assign d_ret_valid = in_r & own_d & rvalid;
    assign d_ret_last  = in_r & own_d & rlast;
    assign d_ret_data  = (in_r & own_d) ? rdata : '0;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rstn && rvalid) begin
            if (state != S_R)
                $error("cache_axi_rd_arbiter: rvalid seen outside R state");
            else if (rid != arid)
                $error("cache_axi_rd_arbiter: rid %0d differs from arid %0d", rid, arid);
        end
    end
`endif

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Directed bench for cache_axi_rd_arbiter: single-client bursts, contention, AR stall,
// R backpressure and mid-burst reset, with a minimal AXI slave driven step by step.
module tb_cache_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_r_req, i_r_rdy, i_r_data_ready, i_ret_valid, i_ret_last;
    logic [31:0] i_r_addr, i_ret_data;
    logic [7:0]  i_r_length;
    logic [2:0]  i_r_size;
    logic        d_r_req, d_r_rdy, d_r_data_ready, d_ret_valid, d_ret_last;
    logic [31:0] d_r_addr, d_ret_data;
    logic [7:0]  d_r_length;
    logic [2:0]  d_r_size;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arid, rid;
    logic        arvalid, arready, rlast, rvalid, rready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_axi_rd_arbiter dut (
        .clk(clk), .rstn(rstn),
        .i_r_req(i_r_req), .i_r_addr(i_r_addr), .i_r_length(i_r_length), .i_r_size(i_r_size),
        .i_r_rdy(i_r_rdy), .i_r_data_ready(i_r_data_ready), .i_ret_valid(i_ret_valid),
        .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
        .d_r_req(d_r_req), .d_r_addr(d_r_addr), .d_r_length(d_r_length), .d_r_size(d_r_size),
        .d_r_rdy(d_r_rdy), .d_r_data_ready(d_r_data_ready), .d_ret_valid(d_ret_valid),
        .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rid(rid), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".arvalid"}, 32'(arvalid), 32'd0);
        chk({tag, ".rready"}, 32'(rready), 32'd0);
        chk({tag, ".i_r_rdy"}, 32'(i_r_rdy), 32'd0);
        chk({tag, ".d_r_rdy"}, 32'(d_r_rdy), 32'd0);
        chk({tag, ".i_ret_valid"}, 32'(i_ret_valid), 32'd0);
        chk({tag, ".d_ret_valid"}, 32'(d_ret_valid), 32'd0);
        chk({tag, ".i_ret_data"}, i_ret_data, 32'd0);
        chk({tag, ".d_ret_data"}, d_ret_data, 32'd0);
        chk({tag, ".arburst"}, 32'(arburst), 32'd1);
    endtask

    // Drive beats [0, nbeats) of a burst of total_len beats; owner stalls 3 cycles at stall_at.
    task automatic do_burst(input bit d, input int nbeats, input int total_len,
                            input logic [31:0] base, input int stall_at);
        for (int b = 0; b < nbeats; b++) begin
            rvalid = 1'b1;
            rdata  = base + 32'(b * 7);
            rlast  = (b == total_len - 1);
            rid    = d ? 4'd1 : 4'd0;
            if (b == stall_at) begin
                if (d) d_r_data_ready = 1'b0; else i_r_data_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    chk("stall.rready", 32'(rready), 32'd0);
                    tick();
                end
                d_r_data_ready = 1'b1;
                i_r_data_ready = 1'b1;
            end
            #1;
            chk("beat.rready", 32'(rready), 32'd1);
            chk("beat.own_valid", 32'(d ? d_ret_valid : i_ret_valid), 32'd1);
            chk("beat.own_data", d ? d_ret_data : i_ret_data, base + 32'(b * 7));
            chk("beat.own_last", 32'(d ? d_ret_last : i_ret_last), 32'(b == total_len - 1));
            chk("beat.other_valid", 32'(d ? i_ret_valid : d_ret_valid), 32'd0);
            chk("beat.other_data", d ? i_ret_data : d_ret_data, 32'd0);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rdata  = '0;
    endtask

    initial begin
        bit exp_d;
        rstn = 1'b0;
        i_r_req = 1'b1; i_r_addr = 32'h1C00_0040; i_r_length = 8'd15; i_r_size = 3'd2;
        d_r_req = 1'b0; d_r_addr = '0; d_r_length = '0; d_r_size = '0;
        i_r_data_ready = 1'b1; d_r_data_ready = 1'b1;
        arready = 1'b1; rdata = '0; rid = '0; rlast = 1'b0; rvalid = 1'b0;

        // Reset: request held high must not produce an AR
        tick(); tick();
        chk_quiet("reset");
        chk("reset.araddr", araddr, 32'd0);
        chk("reset.arid", 32'(arid), 32'd0);
        i_r_req = 1'b0;
        rstn = 1'b1;
        tick();

        // 1: I-cache only, 16-beat burst
        i_r_req = 1'b1;
        #1 chk("t1.pre_arvalid", 32'(arvalid), 32'd0);
        tick();
        chk("t1.arvalid", 32'(arvalid), 32'd1);
        chk("t1.araddr", araddr, 32'h1C00_0040);
        chk("t1.arlen", 32'(arlen), 32'd15);
        chk("t1.arsize", 32'(arsize), 32'd2);
        chk("t1.arid", 32'(arid), 32'd0);
        chk("t1.i_r_rdy", 32'(i_r_rdy), 32'd1);
        chk("t1.d_r_rdy", 32'(d_r_rdy), 32'd0);
        i_r_req = 1'b0;
        tick();
        chk("t1.arvalid_low", 32'(arvalid), 32'd0);
        chk("t1.i_r_rdy_once", 32'(i_r_rdy), 32'd0);
        do_burst(1'b0, 16, 16, 32'hA000_0000, -1);
        #1 chk_quiet("t1.idle");
        tick();
        chk("t1.no_new_ar", 32'(arvalid), 32'd0);

        // 2: simultaneous requests, D wins, I follows after one IDLE cycle
        i_r_addr = 32'h1C00_0080; i_r_length = 8'd3;
        d_r_addr = 32'h2000_0100; d_r_length = 8'd3; d_r_size = 3'd2;
        i_r_req = 1'b1; d_r_req = 1'b1;
        tick();
        chk("t2.arid_d", 32'(arid), 32'd1);
        chk("t2.araddr_d", araddr, 32'h2000_0100);
        chk("t2.d_r_rdy", 32'(d_r_rdy), 32'd1);
        chk("t2.i_r_rdy", 32'(i_r_rdy), 32'd0);
        d_r_req = 1'b0;
        tick();
        do_burst(1'b1, 4, 4, 32'hB000_0000, -1);
        #1 chk("t2.idle_gap", 32'(arvalid), 32'd0);
        tick();
        chk("t2.arvalid_i", 32'(arvalid), 32'd1);
        chk("t2.arid_i", 32'(arid), 32'd0);
        chk("t2.araddr_i", araddr, 32'h1C00_0080);
        chk("t2.i_r_rdy", 32'(i_r_rdy), 32'd1);
        i_r_req = 1'b0;
        tick();
        do_burst(1'b0, 4, 4, 32'hC000_0000, -1);

        // 3: three contention rounds; loser drops its request after the grant
        i_r_length = 8'd1; d_r_length = 8'd1;
        for (int r = 0; r < 3; r++) begin
`ifdef ARB_RR_EN
            exp_d = (r != 1);
`else
            exp_d = 1'b1;
`endif
            i_r_req = 1'b1; d_r_req = 1'b1;
            tick();
            chk("t3.arid", 32'(arid), exp_d ? 32'd1 : 32'd0);
            chk("t3.d_r_rdy", 32'(d_r_rdy), 32'(exp_d));
            chk("t3.i_r_rdy", 32'(i_r_rdy), 32'(!exp_d));
            i_r_req = 1'b0; d_r_req = 1'b0;
            tick();
            do_burst(exp_d, 2, 2, 32'hD000_0000 + 32'(r << 8), -1);
            tick();
            chk("t3.dropped_not_issued", 32'(arvalid), 32'd0);
        end

        // 4: D uncached single beat with arready low for 5 cycles
        d_r_addr = 32'h3000_0004; d_r_length = 8'd0; d_r_size = 3'd1;
        d_r_req = 1'b1; arready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            if (c == 2) d_r_addr = 32'h3000_0FFC;
            #1;
            chk("t4.arvalid", 32'(arvalid), 32'd1);
            chk("t4.araddr", araddr, 32'h3000_0004);
            chk("t4.arlen", 32'(arlen), 32'd0);
            chk("t4.arsize", 32'(arsize), 32'd1);
            chk("t4.d_r_rdy_wait", 32'(d_r_rdy), 32'd0);
            tick();
        end
        arready = 1'b1;
        #1 chk("t4.d_r_rdy", 32'(d_r_rdy), 32'd1);
        d_r_req = 1'b0;
        tick();
        do_burst(1'b1, 1, 1, 32'hE000_0000, -1);

        // 5: owner backpressure for 3 cycles mid-burst
        i_r_addr = 32'h1C00_0400; i_r_length = 8'd15; i_r_size = 3'd2;
        i_r_req = 1'b1;
        tick();
        chk("t5.arvalid", 32'(arvalid), 32'd1);
        i_r_req = 1'b0;
        tick();
        do_burst(1'b0, 16, 16, 32'hF000_0000, 5);

        // 6: reset during beat 7 of 16, then a fresh I request
        i_r_addr = 32'h1C00_0800;
        i_r_req = 1'b1;
        tick();
        i_r_req = 1'b0;
        tick();
        do_burst(1'b0, 7, 16, 32'h1234_0000, -1);
        rvalid = 1'b1; rdata = 32'h1234_0000 + 32'd49; rid = 4'd0;
        #1 chk("t6.beat7_valid", 32'(i_ret_valid), 32'd1);
        rstn = 1'b0;
        #1;
        chk_quiet("t6.async_reset");
        chk("t6.araddr", araddr, 32'd0);
        chk("t6.arlen", 32'(arlen), 32'd0);
        rvalid = 1'b0; rdata = '0;
        tick(); tick();
        rstn = 1'b1;
        i_r_addr = 32'h1C00_0200; i_r_length = 8'd1;
        i_r_req = 1'b1;
        tick();
        chk("t6.arvalid", 32'(arvalid), 32'd1);
        chk("t6.arid", 32'(arid), 32'd0);
        chk("t6.araddr", araddr, 32'h1C00_0200);
        chk("t6.i_r_rdy", 32'(i_r_rdy), 32'd1);
        i_r_req = 1'b0;
        tick();
        do_burst(1'b0, 2, 2, 32'h5555_0000, -1);
        #1 chk_quiet("t6.idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
